seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative signed integer divider: the inverse operation of the team's combinational Booth multiplier.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands using restoring division, one quotient bit per clock.
- Sits beside the multiplier in the ALU datapath.
- Uses a start/busy/done handshake so the ALU controller can stall for the multi-cycle result.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a division; sampled only when not busy.
- dividend  in  WIDTH  numerator, two's complement; sampled with accepted start.
- divisor  in  WIDTH  denominator, two's complement; sampled with accepted start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse: results valid.
- quotient  out  WIDTH  signed quotient, truncated toward zero; held until next accepted start.
- remainder  out  WIDTH  signed remainder, sign of dividend; held.
- div_by_zero  out  1  set with done when divisor==0; held with results.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst). Any cycle with rst=1 forces, on that edge:
  - state=IDLE;
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0;
  - counter=0.
  - Reset mid-operation abandons the division; no done is produced.
- States:
  - IDLE: done=0. start=1 → latch operands, go to CALC, or to FIX if divisor==0.
  - CALC: one restoring step per cycle for exactly WIDTH cycles.
  - FIX: apply signs, load outputs.
  - DONE: done=1 for one cycle, then IDLE. start is also accepted in DONE (back-to-back operation).
- Latency:
  - start sampled at edge T.
  - busy=1 for cycles T+1..T+WIDTH+1; done=1 at T+WIDTH+2 with busy=0.
  - Divide-by-zero: busy=1 at T+1 (FIX), done at T+2.
- start while busy: ignored; operands are not re-sampled.
- Operand preparation on accept:
  - Latch sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - Store magnitudes as WIDTH-bit unsigned; 0x8000_0000 magnitude is 2^31 and must be correct.
- Step (restoring division):
  - partial = {rem[WIDTH-1:0], q[MSB]}, WIDTH+1 bits.
  - trial = partial − |divisor|.
  - trial ≥ 0: rem=trial, shift 1 into q LSB. Otherwise rem=partial, shift 0.
- FIX:
  - quotient = sign_q ? −q : q; remainder = sign_r ? −rem : rem (WIDTH bits, wrap).
  - Overflow case (most-negative / −1): quotient = 0x8000_0000 (wrapped), remainder = 0, div_by_zero=0.
- Divide by zero: quotient = all ones, remainder = dividend unchanged, div_by_zero=1.
- Outputs change only in FIX and on reset; they are held through IDLE.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement, with sign handling exactly as above.
- Undefined: operands and results are unsigned; no magnitude or sign-fix logic; overflow case does not exist.
- Unchanged either way: divide-by-zero rules and latency.

Decomposition:
- Package div_pkg:
  - DIV_WIDTH default constant;
  - state enum {IDLE, CALC, FIX, DONE};
  - counter width constant $clog2(DIV_WIDTH+1).
- Sub-module div_step:
  - combinational, one restoring iteration;
  - inputs rem, q, divisor magnitude; outputs rem_next, q_next;
  - instantiated once, mirroring the multiplier's per-level block.

Test Plan:
1. Basic and latency: start at T with 100 / 7 → done at T+34, quotient=14, remainder=2, div_by_zero=0; busy high T+1..T+33.
2. Signs: −100 / 7 → quotient=0xFFFF_FFF2 (−14), remainder=0xFFFF_FFFE (−2); also 100 / −7 → quotient=−14, remainder=2.
3. Divide by zero: 5 / 0 → done at T+2, div_by_zero=1, quotient=0xFFFF_FFFF, remainder=5.
4. Overflow: 0x8000_0000 / 0xFFFF_FFFF → quotient=0x8000_0000, remainder=0; also 0x8000_0000 / 1 → quotient=0x8000_0000, remainder=0.
5. Reset and busy start:
   - rst=1 at T+10 of a 100 / 7 run → next cycle busy=0, done=0, outputs 0; no done pulse follows.
   - A second start at T+5 with 9 / 3 is ignored; the first run still yields 14 / 2.
6. Back-to-back: start held high → second start (81 / 9) accepted in the DONE cycle; quotient=9, remainder=0 exactly WIDTH+2 cycles later.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared definitions for the sequential divider (seq_divider).
//   DIV_WIDTH   default operand/result width
//   DIV_CNT_W   step-counter width for the default width
//   div_state_e controller state encoding
//   cnt_bits()  counter width needed to count up to a given width
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Enough bits to hold any value 0..w.
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if : request/result bundle between the ALU controller and the
// sequential divider.
//   start, dividend, divisor                      controller -> divider
//   busy, done, quotient, remainder, div_by_zero  divider -> controller
// Modports: master (controller side), slave (divider side).
// ---------------------------------------------------------------------------
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_step.sv
// ---------------------------------------------------------------------------
// div_step : one combinational restoring-division iteration.
//   rem      running partial remainder (always < dvs)
//   q        dividend bits still to be consumed (MSB first); quotient bits
//            shift in at the LSB
//   dvs      divisor magnitude
//   rem_next / q_next  values after this iteration
// ---------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;
  logic           fits;

  // Bring down the next dividend bit and try subtracting the divisor.
  always_comb begin
    partial = {rem, q[WIDTH-1]};
    trial   = partial - {1'b0, dvs};
    // "trial >= 0" in the restoring algorithm is simply "no borrow".
    fits    = (partial >= {1'b0, dvs});
    if (fits) begin
      rem_next = trial[WIDTH-1:0];
    end else begin
      rem_next = partial[WIDTH-1:0];
    end
    q_next = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider : iterative restoring divider, one quotient bit per clock.
//   clk  system clock (rising edge)
//   rst  synchronous active-high reset
//   bus  seq_divider_if.slave: start/dividend/divisor in,
//        busy/done/quotient/remainder/div_by_zero out (all registered)
// Timing: start accepted at edge T (in IDLE or DONE) -> busy for WIDTH+1
// cycles, done pulse at T+WIDTH+2; a zero divisor skips the iterations and
// reports at T+2.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it, operands and results are unsigned.
// ---------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : cnt_bits(WIDTH);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  div_state_e       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic             dz;

  logic             accept;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  logic sign_q;
  logic sign_r;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q        (q),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_next   (q_next)
  );

  // A new request is taken only when no division is in flight.
  always_comb begin
    if ((state == IDLE) || (state == DONE)) begin
      accept = bus.start;
    end else begin
      accept = 1'b0;
    end
  end

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (bus.dividend[WIDTH-1]) begin
      dividend_mag = ~bus.dividend + ONE;
    end else begin
      dividend_mag = bus.dividend;
    end
    if (bus.divisor[WIDTH-1]) begin
      divisor_mag = ~bus.divisor + ONE;
    end else begin
      divisor_mag = bus.divisor;
    end
`else
    dividend_mag = bus.dividend;
    divisor_mag  = bus.divisor;
`endif
  end

  // Sign restoration; most-negative / -1 falls out as a natural wrap.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (sign_q) begin
      q_fix = ~q + ONE;
    end else begin
      q_fix = q;
    end
    if (sign_r) begin
      r_fix = ~rem + ONE;
    end else begin
      r_fix = rem;
    end
`else
    q_fix = q;
    r_fix = rem;
`endif
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= ZERO;
      bus.remainder   <= ZERO;
      bus.div_by_zero <= 1'b0;
      cnt             <= {CNT_W{1'b0}};
      rem             <= ZERO;
      q               <= ZERO;
      dvs             <= ZERO;
      dz              <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (accept) begin
            rem      <= ZERO;
            cnt      <= {CNT_W{1'b0}};
            dvs      <= divisor_mag;
            bus.busy <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r   <= bus.dividend[WIDTH-1];
`endif
            if (bus.divisor == ZERO) begin
              // Keep the raw dividend: it is reported back as the remainder.
              q     <= bus.dividend;
              dz    <= 1'b1;
              state <= FIX;
            end else begin
              q     <= dividend_mag;
              dz    <= 1'b0;
              state <= CALC;
            end
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        CALC: begin
          rem <= rem_next;
          q   <= q_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt   <= {CNT_W{1'b0}};
            state <= FIX;
          end else begin
            cnt   <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            state <= CALC;
          end
        end

        FIX: begin
          if (dz) begin
            bus.quotient    <= ONES;
            bus.remainder   <= q;
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.quotient    <= q_fix;
            bus.remainder   <= r_fix;
            bus.div_by_zero <= 1'b0;
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider : self-checking bench for seq_divider (WIDTH = 32).
// Directed cases (latency, signs, divide-by-zero, overflow, reset, ignored
// start, back-to-back) followed by random operands checked against a plain
// arithmetic reference model. Honours SEQ_DIVIDER_SIGNED_EN like the RTL.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W     = 32;
  localparam int BOUND = 60;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: what the division must produce, from plain arithmetic.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic [31:0] dz);
    int sa;
    int sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 32'd1;
    end else begin
      dz = 32'd0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = a;
      sb = b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      sa = 0;
      sb = 0;
      q  = a / b;
      r  = a % b;
`endif
    end
  endtask

  // Issue one division, optionally poke an ignored start mid-run, and check
  // latency, busy, the one-cycle done pulse and the results.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at);
    logic [31:0] eq, er, edz;
    int k;
    int busy_drop;
    int got;
    ref_div(a, b, eq, er, edz);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq({tag, "_busy_t1"}, {31'd0, bus.busy}, 32'd1);
    k = 0; got = 0; busy_drop = 0;
    while (got == 0 && k < BOUND) begin
      @(posedge clk); #1;
      k++;
      if (bus.done) got = 1;
      else if (!bus.busy) busy_drop = 1;
      if (inject_at != 0 && k == inject_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check_eq({tag, "_latency"}, k, (b == 32'd0) ? 32'd1 : W + 1);
    check_eq({tag, "_busy_hold"}, busy_drop, 32'd0);
    check_eq({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_quot"}, bus.quotient, eq);
    check_eq({tag, "_rem"}, bus.remainder, er);
    check_eq({tag, "_dz"}, {31'd0, bus.div_by_zero}, edz);
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_held_q"}, bus.quotient, eq);
  endtask

  initial begin
    logic [31:0] eq, er, edz, a, b;
    int k, seen;
    n_vec = 0;
    n_err = 0;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_quot", bus.quotient, 32'd0);
    check_eq("rst_rem", bus.remainder, 32'd0);
    check_eq("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;

    do_div("basic", 32'd100, 32'd7, 0);
    do_div("negnum", 32'hFFFF_FF9C, 32'd7, 0);
    do_div("negden", 32'd100, 32'hFFFF_FFF9, 0);
    do_div("divzero", 32'd5, 32'd0, 0);
    do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div("minby1", 32'h8000_0000, 32'd1, 0);
    do_div("ignored", 32'd100, 32'd7, 5);

    // Reset in mid-flight: outputs clear, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_done", {31'd0, bus.done}, 32'd0);
    check_eq("midrst_quot", bus.quotient, 32'd0);
    check_eq("midrst_rem", bus.remainder, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1;
    end
    check_eq("midrst_quiet", seen, 32'd0);

    // Back-to-back: start held high, second request taken in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.dividend = 32'd81; bus.divisor = 32'd9;
    k = 0;
    while (!bus.done && k < BOUND) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("b2b_lat1", k, W + 1);
    check_eq("b2b_q1", bus.quotient, 32'd14);
    check_eq("b2b_r1", bus.remainder, 32'd2);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      bus.start = 1'b0;
    end while (!bus.done && k < BOUND);
    check_eq("b2b_lat2", k, W + 2);
    check_eq("b2b_q2", bus.quotient, 32'd9);
    check_eq("b2b_r2", bus.remainder, 32'd0);

    // Random operands, with corner values mixed in.
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = $urandom_range(1, 15);
        4: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      ref_div(a, b, eq, er, edz);
      do_div("rand", a, b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
